instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 114 +++++++++++
 tb/tb_instr_fetch.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Single-entry instruction fetch stage. It fetches from a
//               combinational instruction memory, hands words to decode over
//               a valid/ready handshake, and supports redirects and a sticky
//               fetch fault.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] c_MEM_WORDS = 32'(MEM_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic        w_pc_bad;
    logic        w_accept;
    logic        w_slot_free;

    // Misaligned, or word index past the end of the attached memory.
    assign w_pc_bad    = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= c_MEM_WORDS);
    assign w_accept    = valid_q & out_ready;
    assign w_slot_free = ~valid_q | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0000_0000;
            opc_q   <= 32'h0000_0000;
            fault_q <= 1'b0;
            count_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        fault_d = fault_q;
        // Accepts are counted even when a redirect flushes the entry.
        count_d = w_accept ? (count_q + 32'd1) : count_q;

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = ST_RUN;
            fault_d = 1'b0;
        end else begin
            if (w_accept) begin
                valid_d = 1'b0;
            end
            if ((state_q == ST_RUN) && fetch_en) begin
                if (w_pc_bad) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end else if (w_slot_free) begin
                    instr_d = imem_data;
                    opc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = valid_q;
    assign out_instr   = instr_q;
    assign out_pc      = opc_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: directed scenarios plus
//               randomized traffic against a behavioural fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fetch_count;

    logic [31:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    logic        m_fault;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    assign imem_data = (imem_addr[31:10] == 22'd0 && imem_addr[1:0] == 2'b00)
                       ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[1:0] == 2'b00 && (a >> 2) < 32'(DEPTH)) return mem[a[9:2]];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        m_pc    = RST_PC;
        m_valid = 1'b0;
        m_instr = '0;
        m_opc   = '0;
        m_fault = 1'b0;
        m_count = '0;
    endtask

    // One rising edge of the fetch stage, described in terms of its rules:
    // accepts empty the slot, redirects win, faults block fetching.
    task automatic model_step();
        logic bad;
        logic acc;
        bad = (m_pc % 4 != 0) || ((m_pc / 4) >= 32'(DEPTH));
        acc = m_valid && out_ready;
        if (acc) m_count = m_count + 1;
        if (redirect_valid) begin
            m_pc    = redirect_pc;
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else begin
            if (acc) m_valid = 1'b0;
            if (!m_fault && fetch_en) begin
                if (bad) begin
                    m_fault = 1'b1;
                end else if (!m_valid) begin
                    m_instr = mem_word(m_pc);
                    m_opc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 4;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        #1;
        n_checks++;
        if ({imem_addr, out_valid, out_instr, out_pc, fault, fetch_count} !==
            {RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%h v=%b instr=%h pc=%h f=%b cnt=%h, expected all zero",
                     imem_addr, out_valid, out_instr, out_pc, fault, fetch_count);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] w [4];
        w[0] = 32'hA000_000A; w[1] = 32'hB000_000B;
        w[2] = 32'hC000_000C; w[3] = 32'hD000_000D;
        for (int i = 0; i < 4; i++) mem[i] = w[i];
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(k * 4), w[k]}) begin
                n_fail++;
                $display("FAIL seq_fetch%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, out_valid, out_pc, out_instr, 32'(k * 4), w[k]);
            end
        end
        tick();
        n_checks++;
        if (fetch_count !== 32'd4) begin
            n_fail++;
            $display("FAIL seq_count: got %0d expected 4", fetch_count);
        end
    endtask

    task automatic test_stall();
        logic [31:0] cnt0;
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        cnt0 = fetch_count;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'd8, mem[2], 32'd12}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h addr=%h expected v=1 pc=8 instr=%h addr=c",
                         k, out_valid, out_pc, out_instr, imem_addr, mem[2]);
            end
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({fetch_count, out_pc} !== {cnt0 + 32'd1, 32'd12}) begin
            n_fail++;
            $display("FAIL stall_release: got cnt=%0d pc=%h expected cnt=%0d pc=c",
                     fetch_count, out_pc, cnt0 + 32'd1);
        end
    endtask

    task automatic test_redirect();
        mem[16] = 32'h4040_4040;
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        n_checks++;
        if ({out_valid, imem_addr} !== {1'b0, 32'h40}) begin
            n_fail++;
            $display("FAIL redirect_flush: got v=%b addr=%h expected v=0 addr=40", out_valid, imem_addr);
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h40, 32'h4040_4040}) begin
            n_fail++;
            $display("FAIL redirect_fetch: got v=%b pc=%h instr=%h expected v=1 pc=40 instr=40404040",
                     out_valid, out_pc, out_instr);
        end
        // Accept coinciding with a redirect still counts.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({fetch_count, out_valid, imem_addr} !== {32'd1, 1'b0, 32'h80}) begin
            n_fail++;
            $display("FAIL redirect_accept: got cnt=%0d v=%b addr=%h expected cnt=1 v=0 addr=80",
                     fetch_count, out_valid, imem_addr);
        end
    endtask

    task automatic test_fault_range();
        do_reset();
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3FC;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++;
        if ({out_valid, out_pc, imem_addr, fault} !== {1'b1, 32'h3FC, 32'h400, 1'b0}) begin
            n_fail++;
            $display("FAIL range_last: got v=%b pc=%h addr=%h f=%b expected v=1 pc=3fc addr=400 f=0",
                     out_valid, out_pc, imem_addr, fault);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({fault, out_valid, imem_addr, fetch_count} !== {1'b1, 1'b0, 32'h400, 32'd1}) begin
                n_fail++;
                $display("FAIL range_fault%0d: got f=%b v=%b addr=%h cnt=%0d expected f=1 v=0 addr=400 cnt=1",
                         k, fault, out_valid, imem_addr, fetch_count);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if ({fault, imem_addr} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL range_clear: got f=%b addr=%h expected f=0 addr=0", fault, imem_addr);
        end
        tick();
        n_checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL range_resume: got v=%b pc=%h expected v=1 pc=0", out_valid, out_pc);
        end
    endtask

    task automatic test_fault_misalign();
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++;
        if ({fault, out_valid, imem_addr} !== {1'b1, 1'b0, 32'h6}) begin
            n_fail++;
            $display("FAIL misalign_fault: got f=%b v=%b addr=%h expected f=1 v=0 addr=6",
                     fault, out_valid, imem_addr);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({imem_addr, out_valid, out_instr, out_pc, fault, fetch_count} !==
            {RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%h v=%b instr=%h pc=%h f=%b cnt=%h expected all zero",
                     imem_addr, out_valid, out_instr, out_pc, fault, fetch_count);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        tick();
        n_checks++;
        if ({out_valid, out_pc, imem_addr} !== {1'b1, RST_PC, RST_PC + 32'd4}) begin
            n_fail++;
            $display("FAIL first_load_after_reset: got v=%b pc=%h addr=%h expected v=1 pc=%h addr=%h",
                     out_valid, out_pc, imem_addr, RST_PC, RST_PC + 32'd4);
        end
    endtask

    task automatic test_reset_mid_handshake();
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        n_checks++;
        if ({out_valid, fetch_count} !== {1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_handshake: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, fetch_count);
        end
        tick();
        n_checks++;
        if (fetch_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_no_accept: got cnt=%0d expected 0", fetch_count);
        end
    endtask

    task automatic test_random();
        logic [129:0] obs;
        logic [129:0] exp;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            fetch_en       = ($urandom % 8) != 0;
            out_ready      = ($urandom % 4) != 0;
            redirect_valid = ($urandom % 16) == 0;
            case ($urandom % 5)
                0, 1:    redirect_pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
                2:       redirect_pc = 32'(DEPTH * 4) - 32'(4 * $urandom_range(1, 3));
                3:       redirect_pc = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                default: redirect_pc = $urandom | 32'h0000_0400;
            endcase
            if (($urandom % 500) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
                model_reset();
            end
            tick();
            obs = {imem_addr, out_valid, out_instr, out_pc, fault, fetch_count};
            exp = {m_pc, m_valid, m_instr, m_opc, m_fault, m_count};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got {addr,v,instr,pc,f,cnt}=%h expected %h", c, obs, exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i);
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault_range();
        test_fault_misalign();
        test_reset_mid_handshake();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
